// File: rtl/enc256to8.sv
// 256-to-8 lowest-set-bit priority encoder, two registered stages with
// valid/ready flow control on both sides; also flags all-zero and multi-hot input.
module enc256to8 (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out,
    output logic         none,
    output logic         multi,
    output logic         out_valid,
    input  logic         out_ready
);

    function automatic logic [3:0] low16(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic many16(input logic [15:0] v);
        return |(v & (v - 16'd1));
    endfunction

    logic              adv1;
    logic              adv2;

    logic              s1_valid_q;
    logic              s1_valid_d;
    logic [15:0]       s1_any_q;
    logic [15:0]       s1_any_d;
    logic [15:0]       s1_multi_q;
    logic [15:0]       s1_multi_d;
    logic [15:0][3:0]  s1_idx_q;
    logic [15:0][3:0]  s1_idx_d;

    logic              out_valid_q;
    logic              out_valid_d;
    logic [7:0]        out_q;
    logic [7:0]        out_d;
    logic              none_q;
    logic              none_d;
    logic              multi_q;
    logic              multi_d;

    logic [15:0]       grp_any;
    logic [15:0]       grp_multi;
    logic [15:0][3:0]  grp_idx;
    logic [3:0]        sel_g;

    assign adv2     = !out_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    // Stage 1: independent per-group summaries of 16-bit slices.
    always_comb begin
        grp_any   = '0;
        grp_multi = '0;
        grp_idx   = '0;
        for (int g = 0; g < 16; g++) begin
            grp_any[g]   = |in[g*16 +: 16];
            grp_multi[g] = many16(in[g*16 +: 16]);
            grp_idx[g]   = low16(in[g*16 +: 16]);
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_any_d   = s1_any_q;
        s1_multi_d = s1_multi_q;
        s1_idx_d   = s1_idx_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_any_d   = grp_any;
                s1_multi_d = grp_multi;
                s1_idx_d   = grp_idx;
            end
        end
    end

    // Stage 2: lowest non-empty group selects the upper nibble.
    assign sel_g = low16(s1_any_q);

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        none_d      = none_q;
        multi_d     = multi_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                none_d  = ~|s1_any_q;
                multi_d = (|s1_multi_q) || many16(s1_any_q);
                out_d   = none_d ? 8'h00 : {sel_g, s1_idx_q[sel_g]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_any_q    <= '0;
            s1_multi_q  <= '0;
            s1_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_q       <= 8'h00;
            none_q      <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_any_q    <= s1_any_d;
            s1_multi_q  <= s1_multi_d;
            s1_idx_q    <= s1_idx_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            none_q      <= none_d;
            multi_q     <= multi_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign none      = none_q;
    assign multi     = multi_q;

endmodule

// File: tb/tb_enc256to8.sv
// Bench for enc256to8: vector table, sweep, backpressure, reset flush
// and a randomized run against a lowest-set-bit scoreboard.
module tb_enc256to8;

    typedef struct packed {
        logic [7:0] o;
        logic       n;
        logic       m;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
    } sb_t;

    typedef struct {
        logic [255:0] vin;
        logic [7:0]   eout;
        logic         enone;
        logic         emulti;
    } vec_t;

    logic         clk;
    logic         reset;
    logic [255:0] din;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out;
    logic         none;
    logic         multi;
    logic         out_valid;
    logic         out_ready;

    int           checks;
    int           fails;
    int           cyc;
    bit           lat_mode;
    bit           stall_q;
    logic [10:0]  hold;
    sb_t          sb[$];

    enc256to8 dut (
        .clk       (clk),
        .reset     (reset),
        .in        (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .none      (none),
        .multi     (multi),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [255:0] d);
        res_t r;
        r.o = 8'h00;
        r.n = (d == '0);
        r.m = ($countones(d) > 1);
        for (int i = 255; i >= 0; i--) begin
            if (d[i]) r.o = 8'(i);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d",
                     nm, act, exp, cyc);
        end
    endtask

    // One cycle: drive at negedge, evaluate handshakes just before the edge.
    task automatic step(input logic v, input logic [255:0] d,
                        input logic ordy, input res_t e, output logic acc);
        logic del;
        sb_t  ent;
        @(negedge clk);
        if (stall_q) chk("stall_hold", {out_valid, out, none, multi}, hold);
        in_valid  = v;
        din       = d;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        del = out_valid && out_ready;
        if (del) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious_out actual=%0d required=none cyc=%0d",
                         out, cyc);
            end else begin
                ent = sb.pop_front();
                chk("result", {out, none, multi}, ent.r);
                if (lat_mode) chk("latency", cyc - ent.cyc, 2);
            end
        end
        if (acc) sb.push_back('{e, cyc});
        stall_q = out_valid && !out_ready;
        hold    = {out_valid, out, none, multi};
        cyc++;
    endtask

    task automatic send(input logic [255:0] d, input res_t e, input logic ordy);
        logic a;
        a = 1'b0;
        for (int t = 0; t < 50 && !a; t++) step(1'b1, d, ordy, e, a);
        if (!a) chk("send_timeout", 0, 1);
    endtask

    task automatic drain(input int n);
        logic a;
        repeat (n) step(1'b0, '0, 1'b1, '0, a);
        chk("drained", sb.size(), 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        stall_q = 1'b0;
        #1;
        chk("rst_state", {out_valid, out, none, multi}, 11'h000);
        chk("rst_in_ready", in_ready, 1);
    endtask

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        logic [255:0] one;
        one = 256'd1;
        v = '0;
        case ($urandom_range(0, 4))
            0: v = '0;
            1: v = one << $urandom_range(0, 255);
            2: v = (one << $urandom_range(0, 255)) | (one << $urandom_range(0, 255));
            3: for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom();
            default: begin
                for (int w = 0; w < 8; w++)
                    v[w*32 +: 32] = $urandom() & $urandom() & $urandom() & $urandom();
                if ($urandom_range(0, 1) == 1) v[127:0] = '0;
            end
        endcase
        return v;
    endfunction

    initial begin
        vec_t         tbl[6];
        logic [255:0] one;
        logic         a;
        int           acc_n;
        int           steps;
        logic         v;
        logic         r;
        logic [255:0] d;

        checks    = 0;
        fails     = 0;
        cyc       = 0;
        lat_mode  = 1'b0;
        stall_q   = 1'b0;
        hold      = '0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        one       = 256'd1;

        do_reset(2);

        tbl[0] = '{'0, 8'd0, 1'b1, 1'b0};
        tbl[1] = '{(one << 200) | (one << 7), 8'd7, 1'b0, 1'b1};
        tbl[2] = '{(one << 33) | (one << 34), 8'd33, 1'b0, 1'b1};
        tbl[3] = '{'1, 8'd0, 1'b0, 1'b1};
        tbl[4] = '{one << 128, 8'd128, 1'b0, 1'b0};
        tbl[5] = '{(one << 15) | (one << 16), 8'd15, 1'b0, 1'b1};
        foreach (tbl[i])
            send(tbl[i].vin, {tbl[i].eout, tbl[i].enone, tbl[i].emulti}, 1'b1);
        drain(4);

        lat_mode = 1'b1;
        for (int k = 0; k < 256; k++) begin
            d = one << k;
            step(1'b1, d, 1'b1, model(d), a);
            chk("sweep_accept", a, 1);
        end
        drain(4);
        lat_mode = 1'b0;

        send(one << 3, model(one << 3), 1'b0);
        send(one << 100, model(one << 100), 1'b0);
        step(1'b1, one << 255, 1'b0, model(one << 255), a);
        chk("bp_in_ready", a, 0);
        chk("bp_hold", {out_valid, out}, {1'b1, 8'd3});
        repeat (3) step(1'b1, '1, 1'b0, model('1), a);
        chk("bp_still_held", {out_valid, out}, {1'b1, 8'd3});
        chk("bp_depth", sb.size(), 2);
        send(one << 255, model(one << 255), 1'b1);
        drain(5);

        step(1'b1, one << 50, 1'b1, model(one << 50), a);
        chk("rf_accept", a, 1);
        do_reset(1);
        repeat (6) step(1'b0, one << 50, 1'b1, '0, a);
        chk("rf_flushed", out_valid, 0);

        acc_n = 0;
        steps = 0;
        while (acc_n < 10000 && steps < 40000) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            d = rand_vec();
            step(v, d, r, model(d), a);
            if (a) acc_n++;
            steps++;
        end
        chk("rand_count", acc_n, 10000);
        drain(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
